// File: rtl/dac_hpf_multichan.sv
`default_nettype none
// ============================================================================
// Module   : dac_hpf_multichan
// Brief    : Time-multiplexed HPF / gain / deadband / threshold for NUM_DAC outputs
// Revision : 1.0
// ============================================================================
module dac_hpf_multichan #(
    parameter int NUM_DAC  = 8,
    parameter int NUM_CHAN = 32,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    localparam int CH_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
    localparam int IDX_W   = (NUM_DAC > 1) ? $clog2(NUM_DAC) : 1
) (
    input  logic                      dataclk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CH_W-1:0]           s_chan,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      sw_ref_en,
    input  logic [DATA_W-1:0]         sw_ref,
    input  logic [NUM_DAC*CH_W-1:0]   dac_src,
    input  logic [NUM_DAC-1:0]        dac_en,
    input  logic [NUM_DAC*3-1:0]      dac_gain,
    input  logic                      hpf_en,
    input  logic [COEF_W-1:0]         hpf_coef,
    input  logic [6:0]                noise_sup,
    input  logic [NUM_DAC*DATA_W-1:0] thr,
    input  logic [NUM_DAC-1:0]        thr_pol,
    output logic [NUM_DAC*DATA_W-1:0] dac_code,
    output logic [NUM_DAC-1:0]        thr_out,
    output logic                      out_valid,
    output logic [IDX_W-1:0]          out_idx
);

    localparam int                ST_W     = DATA_W + 1 + COEF_W;
    localparam int                SH_W     = DATA_W + 8;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DAC - 1);
    localparam logic [DATA_W-1:0] D_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ST_W-1:0]   ST_MAX   = {1'b0, {(ST_W-1){1'b1}}};
    localparam logic [ST_W-1:0]   ST_MIN   = {1'b1, {(ST_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              drain_q, drain_d;
    logic              w_capture;
    logic              w_scan;

    logic [CH_W-1:0]   chan_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] ref_q;
    logic              ref_en_q;

    // ------------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        s_ready   = 1'b0;
        w_scan    = 1'b0;
        w_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_capture = 1'b1;
                    state_d   = S_SCAN;
                    idx_d     = '0;
                end
            end
            S_SCAN: begin
                w_scan = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            chan_q   <= '0;
            data_q   <= '0;
            ref_q    <= '0;
            ref_en_q <= 1'b0;
        end else if (w_capture) begin
            chan_q   <= s_chan;
            data_q   <= s_data;
            ref_q    <= sw_ref;
            ref_en_q <= sw_ref_en;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: reference subtraction, filter difference and coefficient product
    // ------------------------------------------------------------------------
    logic signed [ST_W-1:0]   lp_q [NUM_DAC];
    logic signed [DATA_W-1:0] w_x_raw, w_ref_s, w_x;
    logic signed [DATA_W:0]   w_x_diff, w_lp_int, w_d;
    logic signed [ST_W-1:0]   w_d_ext, w_coef_ext, w_prod;
    logic                     w_hit;

    always_comb begin
        w_x_raw  = $signed({~data_q[DATA_W-1], data_q[DATA_W-2:0]});
        w_ref_s  = $signed({~ref_q[DATA_W-1], ref_q[DATA_W-2:0]});
        w_x_diff = {w_x_raw[DATA_W-1], w_x_raw} - {w_ref_s[DATA_W-1], w_ref_s};
        w_x      = w_x_raw;
        if (ref_en_q) begin
            if (w_x_diff[DATA_W] != w_x_diff[DATA_W-1]) begin
                w_x = w_x_diff[DATA_W] ? D_MIN : D_MAX;
            end else begin
                w_x = w_x_diff[DATA_W-1:0];
            end
        end
        // Integer part of the state is an arithmetic shift, i.e. floor division.
        w_lp_int   = lp_q[idx_q][ST_W-1:COEF_W];
        w_d        = {w_x[DATA_W-1], w_x} - w_lp_int;
        w_d_ext    = ST_W'(w_d);
        w_coef_ext = ST_W'($signed({1'b0, hpf_coef}));
        w_prod     = w_d_ext * w_coef_ext;
        w_hit      = w_scan && dac_en[idx_q] &&
                     (dac_src[idx_q*CH_W +: CH_W] == chan_q);
    end

    logic                     s1_vld_q;
    logic [IDX_W-1:0]         s1_idx_q;
    logic signed [DATA_W-1:0] s1_x_q;
    logic signed [DATA_W:0]   s1_d_q;
    logic signed [ST_W-1:0]   s1_prod_q;

    always_ff @(posedge dataclk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_x_q    <= '0;
            s1_d_q    <= '0;
            s1_prod_q <= '0;
        end else begin
            s1_vld_q  <= w_hit;
            s1_idx_q  <= idx_q;
            s1_x_q    <= w_x;
            s1_d_q    <= w_d;
            s1_prod_q <= w_prod;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: gain, deadband, threshold and state update
    // ------------------------------------------------------------------------
    logic signed [DATA_W:0]   w_y;
    logic [2:0]               w_gain;
    logic signed [SH_W-1:0]   w_shift;
    logic [DATA_W-1:0]        w_g, w_gdb, w_code, w_thr_sel;
    logic [DATA_W:0]          w_mag, w_db;
    logic                     w_flag;
    logic signed [ST_W-1:0]   w_lp_cur, w_lp_next;
    logic signed [ST_W:0]     w_lp_sum;

    always_comb begin
        w_y     = hpf_en ? s1_d_q : {s1_x_q[DATA_W-1], s1_x_q};
        w_gain  = dac_gain[s1_idx_q*3 +: 3];
        w_shift = SH_W'(w_y) <<< w_gain;
        if ((&w_shift[SH_W-1:DATA_W-1]) || !(|w_shift[SH_W-1:DATA_W-1])) begin
            w_g = w_shift[DATA_W-1:0];
        end else begin
            w_g = w_shift[SH_W-1] ? D_MIN : D_MAX;
        end
        w_mag     = w_g[DATA_W-1] ? -{w_g[DATA_W-1], w_g} : {w_g[DATA_W-1], w_g};
        w_db      = (DATA_W+1)'({noise_sup, 3'b000});
        w_gdb     = (w_mag < w_db) ? '0 : w_g;
        w_code    = {~w_gdb[DATA_W-1], w_gdb[DATA_W-2:0]};
        w_thr_sel = thr[s1_idx_q*DATA_W +: DATA_W];
        w_flag    = thr_pol[s1_idx_q] ? (w_code >= w_thr_sel) : (w_code <= w_thr_sel);

        w_lp_cur = lp_q[s1_idx_q];
        w_lp_sum = {w_lp_cur[ST_W-1], w_lp_cur} + {s1_prod_q[ST_W-1], s1_prod_q};
        if (w_lp_sum[ST_W] != w_lp_sum[ST_W-1]) begin
            w_lp_next = w_lp_sum[ST_W] ? ST_MIN : ST_MAX;
        end else begin
            w_lp_next = w_lp_sum[ST_W-1:0];
        end
        if (!hpf_en) begin
            w_lp_next = '0;
        end
    end

    logic [NUM_DAC*DATA_W-1:0] dac_code_q;
    logic [NUM_DAC-1:0]        thr_out_q;
    logic                      out_valid_q;
    logic [IDX_W-1:0]          out_idx_q;

    always_ff @(posedge dataclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DAC; i++) begin
                lp_q[i] <= '0;
            end
            dac_code_q  <= {NUM_DAC{D_MIN}};
            thr_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                lp_q[s1_idx_q]                          <= w_lp_next;
                dac_code_q[s1_idx_q*DATA_W +: DATA_W]   <= w_code;
                thr_out_q[s1_idx_q]                     <= w_flag;
                out_idx_q                               <= s1_idx_q;
            end
        end
    end

    assign dac_code  = dac_code_q;
    assign thr_out   = thr_out_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;

endmodule
`default_nettype wire
